// File: rtl/dl_reset_sequencer_if.sv
// hps_io ioctl download bus as seen by the reset sequencer.
interface dl_reset_sequencer_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
  );

  modport slave (
    input ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
  );
endinterface

// File: rtl/dl_reset_sequencer.sv
// Routes ioctl ROM writes to the core loader, latches mode/DIP bytes and
// holds the core in reset until a valid image has loaded and settled.
module dl_reset_sequencer #(
  parameter int unsigned ADDR_W      = 14,
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [7:0]  MODE_INDEX  = 8'd1,
  parameter logic [7:0]  DIP_INDEX   = 8'd254,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ext_reset,
  dl_reset_sequencer_if.slave   ioctl,
  output logic                  core_reset,
  output logic                  dn_wr,
  output logic [ADDR_W-1:0]     dn_addr,
  output logic [7:0]            dn_data,
  output logic [1:0]            game_mode,
  output logic [7:0]            dip0,
  output logic [7:0]            dip1,
  output logic                  rom_loaded,
  output logic                  loading,
  output logic                  overflow
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_NOROM, S_LOADING, S_HOLD, S_RUN} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  hold_cnt, hold_cnt_n;
  logic              rom_dl, rom_dl_q, dl_rise, dl_fall;
  logic              mode_wr, mode_chg, rom_wr, in_range, dip_wr;
  logic              nonzero;
  logic [ADDR_W:0]   byte_cnt;
  logic [7:0]        dip_bytes [8];

  assign rom_dl   = ioctl.ioctl_download && (ioctl.ioctl_index == ROM_INDEX);
  assign dl_rise  = rom_dl && !rom_dl_q;
  assign dl_fall  = !rom_dl && rom_dl_q;
  assign mode_wr  = ioctl.ioctl_wr && (ioctl.ioctl_index == MODE_INDEX);
  assign mode_chg = mode_wr && (ioctl.ioctl_dout[1:0] != game_mode);
  assign rom_wr   = (state == S_LOADING) && rom_dl && ioctl.ioctl_wr;
  assign in_range = (ioctl.ioctl_addr[24:ADDR_W] == '0);
  assign dip_wr   = ioctl.ioctl_wr && (ioctl.ioctl_index == DIP_INDEX) &&
                    (ioctl.ioctl_addr[24:3] == '0);

  assign dip0 = dip_bytes[0];
  assign dip1 = dip_bytes[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_NOROM;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    unique case (state)
      S_NOROM: ;
      S_LOADING: begin
        if (dl_fall) begin
          if (nonzero && (byte_cnt != '0)) begin
            state_n    = S_HOLD;
            hold_cnt_n = HOLD_LOAD;
          end else begin
            state_n = S_NOROM;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt != '0)  hold_cnt_n = hold_cnt - 1'b1;
        else if (!ext_reset) state_n    = S_RUN;
      end
      S_RUN: ;
      default: state_n = S_NOROM;
    endcase
    if (mode_chg && ((state == S_RUN) || (state == S_HOLD))) begin
      state_n    = S_HOLD;
      hold_cnt_n = HOLD_LOAD;
    end
    // A new ROM download outranks a mode-change re-hold.
    if (dl_rise) state_n = S_LOADING;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Previous-download flag resets high so a download already running
      // when reset drops is not mistaken for a fresh rising edge.
      rom_dl_q   <= 1'b1;
      core_reset <= 1'b1;
      dn_wr      <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= '0;
      game_mode  <= '0;
      rom_loaded <= 1'b0;
      loading    <= 1'b0;
      overflow   <= 1'b0;
      nonzero    <= 1'b0;
      byte_cnt   <= '0;
      for (int unsigned i = 0; i < 8; i++) dip_bytes[i] <= '0;
    end else begin
      rom_dl_q <= rom_dl;
      dn_wr    <= 1'b0;
      if (dl_rise) begin
        rom_loaded <= 1'b0;
        overflow   <= 1'b0;
        nonzero    <= 1'b0;
        byte_cnt   <= '0;
        loading    <= 1'b1;
      end else if (rom_wr) begin
        if (in_range) begin
          dn_wr   <= 1'b1;
          dn_addr <= ioctl.ioctl_addr[ADDR_W-1:0];
          dn_data <= ioctl.ioctl_dout;
          if (ioctl.ioctl_dout != 8'h00) nonzero <= 1'b1;
          if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if ((state == S_LOADING) && dl_fall) begin
        loading <= 1'b0;
        if (nonzero && (byte_cnt != '0)) rom_loaded <= 1'b1;
      end
      if (mode_wr) game_mode <= ioctl.ioctl_dout[1:0];
      if (dip_wr)  dip_bytes[ioctl.ioctl_addr[2:0]] <= ioctl.ioctl_dout;
      core_reset <= (state_n == S_RUN) ? ext_reset : 1'b1;
    end
  end

endmodule

// File: tb/tb_dl_reset_sequencer.sv
// Directed bench for dl_reset_sequencer with a shortened hold period.
module tb_dl_reset_sequencer;
  localparam int unsigned HOLD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ext_reset = 1'b0;
  logic        core_reset, dn_wr, rom_loaded, loading, overflow;
  logic [13:0] dn_addr;
  logic [7:0]  dn_data, dip0, dip1;
  logic [1:0]  game_mode;
  int          n_assert = 0;
  int          n_fail = 0;

  dl_reset_sequencer_if bus();

  dl_reset_sequencer #(
    .ADDR_W      (14),
    .ROM_INDEX   (8'd0),
    .MODE_INDEX  (8'd1),
    .DIP_INDEX   (8'd254),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ext_reset  (ext_reset),
    .ioctl      (bus),
    .core_reset (core_reset),
    .dn_wr      (dn_wr),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .game_mode  (game_mode),
    .dip0       (dip0),
    .dip1       (dip1),
    .rom_loaded (rom_loaded),
    .loading    (loading),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, ".dn_wr"},      32'(dn_wr),      32'd0);
    chk({tag, ".dn_addr"},    32'(dn_addr),    32'd0);
    chk({tag, ".dn_data"},    32'(dn_data),    32'd0);
    chk({tag, ".game_mode"},  32'(game_mode),  32'd0);
    chk({tag, ".dip0"},       32'(dip0),       32'd0);
    chk({tag, ".dip1"},       32'(dip1),       32'd0);
    chk({tag, ".rom_loaded"}, 32'(rom_loaded), 32'd0);
    chk({tag, ".loading"},    32'(loading),    32'd0);
    chk({tag, ".overflow"},   32'(overflow),   32'd0);
  endtask

  // One ioctl write, then one idle cycle to prove dn_wr is a single pulse.
  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                         input logic exp_wr);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = a;
    bus.ioctl_dout  = d;
    bus.ioctl_wr    = 1'b1;
    tick();
    bus.ioctl_wr = 1'b0;
    if (idx == 8'd0) begin
      chk("dn_wr_pulse", 32'(dn_wr), 32'(exp_wr));
      if (exp_wr) begin
        chk("dn_addr", 32'(dn_addr), 32'(a[13:0]));
        chk("dn_data", 32'(dn_data), 32'(d));
      end
      tick();
      chk("dn_wr_low", 32'(dn_wr), 32'd0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;

    ticks(2);
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();
    chk("idle.core_reset", 32'(core_reset), 32'd1);

    // 16-byte load 0x00..0x0F
    bus.ioctl_index = 8'd0; bus.ioctl_download = 1'b1;
    tick();
    chk("ld1.loading", 32'(loading), 32'd1);
    for (int i = 0; i < 16; i++) wr_byte(8'd0, 25'(i), 8'(i), 1'b1);
    bus.ioctl_download = 1'b0;
    tick();
    chk("ld1.rom_loaded", 32'(rom_loaded), 32'd1);
    chk("ld1.loading_off", 32'(loading), 32'd0);
    chk("ld1.overflow", 32'(overflow), 32'd0);
    ticks(HOLD - 1);
    chk("ld1.hold_last", 32'(core_reset), 32'd1);
    tick();
    chk("ld1.release", 32'(core_reset), 32'd0);

    // ext_reset in RUN follows one cycle late, no re-hold
    ext_reset = 1'b1;
    tick();
    chk("ext.asserted", 32'(core_reset), 32'd1);
    ext_reset = 1'b0;
    tick();
    chk("ext.released", 32'(core_reset), 32'd0);

    // mode change re-pulses reset; same value does not
    wr_byte(8'd1, 25'd0, 8'h02, 1'b0);
    chk("mode.game_mode", 32'(game_mode), 32'd2);
    chk("mode.pulse", 32'(core_reset), 32'd1);
    ticks(HOLD - 1);
    chk("mode.hold_last", 32'(core_reset), 32'd1);
    tick();
    chk("mode.release", 32'(core_reset), 32'd0);
    wr_byte(8'd1, 25'd0, 8'h02, 1'b0);
    chk("mode_same.core_reset", 32'(core_reset), 32'd0);
    tick();
    chk("mode_same.core_reset2", 32'(core_reset), 32'd0);

    // DIP bytes; address 8 is outside the DIP window
    wr_byte(8'd254, 25'd0, 8'hA5, 1'b0);
    wr_byte(8'd254, 25'd1, 8'h3C, 1'b0);
    wr_byte(8'd254, 25'd8, 8'hFF, 1'b0);
    tick();
    chk("dip.dip0", 32'(dip0), 32'hA5);
    chk("dip.dip1", 32'(dip1), 32'h3C);
    chk("dip.core_reset", 32'(core_reset), 32'd0);

    // all-zero image is rejected
    bus.ioctl_index = 8'd0; bus.ioctl_download = 1'b1;
    tick();
    chk("zero.core_reset", 32'(core_reset), 32'd1);
    chk("zero.rom_loaded_clr", 32'(rom_loaded), 32'd0);
    for (int i = 0; i < 8; i++) wr_byte(8'd0, 25'(i), 8'h00, 1'b1);
    bus.ioctl_download = 1'b0;
    tick();
    ticks(3 * HOLD);
    chk("zero.core_reset_held", 32'(core_reset), 32'd1);
    chk("zero.rom_loaded", 32'(rom_loaded), 32'd0);
    chk("zero.loading", 32'(loading), 32'd0);

    // out-of-window byte dropped, in-window bytes still complete the load
    bus.ioctl_download = 1'b1;
    tick();
    wr_byte(8'd0, 25'h4000, 8'h55, 1'b0);
    chk("ovf.overflow", 32'(overflow), 32'd1);
    wr_byte(8'd0, 25'h3FFF, 8'h11, 1'b1);
    wr_byte(8'd0, 25'h0000, 8'h22, 1'b1);
    bus.ioctl_download = 1'b0;
    tick();
    chk("ovf.rom_loaded", 32'(rom_loaded), 32'd1);
    chk("ovf.sticky", 32'(overflow), 32'd1);
    ticks(HOLD);
    chk("ovf.release", 32'(core_reset), 32'd0);

    // reset in the middle of a 32-byte load
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) wr_byte(8'd0, 25'(i), 8'(i + 1), 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("midrst");
    for (int i = 10; i < 32; i++) wr_byte(8'd0, 25'(i), 8'(i + 1), 1'b0);
    chk("midrst.loading", 32'(loading), 32'd0);
    bus.ioctl_download = 1'b0;
    tick();
    chk("midrst.rom_loaded", 32'(rom_loaded), 32'd0);
    chk("midrst.core_reset", 32'(core_reset), 32'd1);

    // fresh download reloads; ext_reset stretches the hold
    bus.ioctl_download = 1'b1;
    tick();
    chk("reload.loading", 32'(loading), 32'd1);
    for (int i = 0; i < 4; i++) wr_byte(8'd0, 25'(i), 8'(8'h80 + i), 1'b1);
    ext_reset = 1'b1;
    bus.ioctl_download = 1'b0;
    tick();
    chk("reload.rom_loaded", 32'(rom_loaded), 32'd1);
    ticks(HOLD);
    chk("reload.ext_hold", 32'(core_reset), 32'd1);
    ext_reset = 1'b0;
    tick();
    chk("reload.release", 32'(core_reset), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dl_reset_sequencer.md
Name: dl_reset_sequencer

Overview:
- Sits between hps_io's ioctl download bus and the game core.
- Routes ROM download writes into the core's ROM loader and latches the game-mode byte and the DIP switch bytes.
- Sequences the core reset: reset is held until a valid ROM image has arrived, then released after a settle period; a game-mode change re-pulses reset.
- Replaces ad-hoc reset/latch glue in the top level with one verified state machine.

Parameters:
- ADDR_W, 14, width of dn_addr; ROM window size is 2**ADDR_W bytes.
- ROM_INDEX, 8'd0, ioctl_index value for ROM data.
- MODE_INDEX, 8'd1, ioctl_index value for the game-mode byte.
- DIP_INDEX, 8'd254, ioctl_index value for DIP bytes.
- HOLD_CYCLES, 1024, clk cycles reset is held after a successful load or mode change; must be ≥1.

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset  in  1  synchronous, active-high; highest priority.
- ext_reset  in  1  user/OSD/board reset request, level.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  byte write strobe, single cycle.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- core_reset  out  1  reset to game core, registered.
- dn_wr  out  1  ROM write strobe to core.
- dn_addr  out  ADDR_W  ROM byte address.
- dn_data  out  8  ROM byte data.
- game_mode  out  2  latched game select.
- dip0  out  8  DIP byte 0.
- dip1  out  8  DIP byte 1.
- rom_loaded  out  1  a valid image has completed.
- loading  out  1  ROM download in progress (LED).
- overflow  out  1  sticky: a ROM byte addressed beyond the window was dropped in the current/last load.

Behaviour:
- Reset values: core_reset=1; dn_wr=0; dn_addr=0; dn_data=0; game_mode=0; dip0=dip1=0; rom_loaded=0; loading=0; overflow=0; state=NOROM; hold counter=0; DIP bytes 2..7=0.
- States: NOROM, LOADING, HOLD, RUN.
- rom_dl = ioctl_download & (ioctl_index==ROM_INDEX). State changes are based on the registered previous value of rom_dl; a rising edge is rom_dl=1 with the previous value 0.
- Download already active when reset deasserts: ignored. A new rising edge is required.
- Any state, on a rom_dl rising edge: go to LOADING. Clear rom_loaded, overflow, nonzero flag and byte count; set loading=1.
- LOADING, per ioctl_wr:
  - If ioctl_addr < 2**ADDR_W: register dn_wr=1, dn_addr=ioctl_addr[ADDR_W-1:0], dn_data=ioctl_dout. Latency is exactly 1 cycle. dn_wr is high for exactly 1 cycle per accepted byte.
  - Otherwise: suppress dn_wr and set overflow.
  - Any accepted byte ≠0 sets the nonzero flag.
  - The byte count (ADDR_W+1 bits) saturates.
- LOADING, on falling rom_dl:
  - loading=0.
  - If nonzero flag and count>0: go to HOLD, load counter=HOLD_CYCLES-1, set rom_loaded=1.
  - Otherwise: go to NOROM.
- HOLD: decrement the counter each cycle. At counter==0 and ext_reset=0, go to RUN. If ext_reset=1, stay in HOLD with the counter frozen at 0.
- RUN: core_reset = registered ext_reset, i.e. 1 cycle late. Released ext_reset returns to RUN behaviour immediately; no re-hold.
- core_reset=1 in NOROM, LOADING and HOLD.
- Mode writes: ioctl_wr & index==MODE_INDEX, in any state. Latch game_mode=ioctl_dout[1:0].
  - If the latched value differs from the current value and state is RUN or HOLD: go to (or restart) HOLD with counter=HOLD_CYCLES-1.
  - Same value: no reset pulse.
- DIP writes: ioctl_wr & index==DIP_INDEX & ioctl_addr[24:3]==0. Write DIP byte[addr[2:0]]; dip0/dip1 reflect bytes 0/1 one cycle later. Allowed in any state; never touches core_reset.
- Simultaneous rom_dl rising edge and mode write: both take effect, and the state goes to LOADING (LOADING has priority over HOLD).
- reset mid-LOADING: all outputs return to reset values; the partially loaded image is invalid; dn_wr=0 from the cycle after reset.

Test Plan:
- Reset, then load 16 bytes 0x00..0x0F at addr 0..15 with index 0 → dn_wr pulses 16× with 1-cycle latency; after download falls, rom_loaded=1; core_reset falls exactly HOLD_CYCLES cycles later.
- Load 8 bytes, all 0x00 → state NOROM; core_reset stays 1 indefinitely; rom_loaded=0.
- Write byte to addr 0x4000 (ADDR_W=14) → no dn_wr, overflow=1; in-range nonzero bytes still complete the load.
- In RUN, mode write 0x02 → game_mode=2, core_reset=1 for HOLD_CYCLES cycles. Repeat the write with 0x02 → core_reset stays 0.
- DIP writes 0xA5@addr0, 0x3C@addr1, 0xFF@addr8 → dip0=0xA5, dip1=0x3C, addr8 ignored; core_reset unaffected.
- Assert reset for 1 cycle in the middle of a 32-byte load → all outputs at reset values; the remaining writes produce no dn_wr. A fresh download edge reloads successfully.
